// File: rtl/uart_mmio_pkg.sv
// Shared register offsets, STATUS bit positions and transmitter state type
// for the memory-mapped UART transmitter.
package uart_mmio_pkg;

  localparam logic [31:0] TXDATA_OFF = 32'd0;
  localparam logic [31:0] STATUS_OFF = 32'd4;
  localparam logic [31:0] BAUD_OFF   = 32'd8;
  localparam logic [31:0] WINDOW_LEN = 32'd12;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_ACTIVE  = 2;
  localparam int ST_OVF     = 4;
  localparam int ST_CNT_LSB = 5;
  localparam int ST_CNT_MSB = 7;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  // A divisor below 2 would make the bit counter degenerate, so clamp it.
  function automatic logic [15:0] eff_div(input logic [15:0] div);
    return (div < 16'd2) ? 16'd2 : div;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count; a push while full is accepted
// when a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop_i && (count != '0);
  assign do_push = push_i && ((count != FULL_CNT) || do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign data_o  = mem[rd_ptr];
  assign full_o  = (count == FULL_CNT);
  assign empty_o = (count == '0);
  assign count_o = count;

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/BAUD register window,
// byte FIFO and a serialiser that runs frames back-to-back while data is queued.
module mmio_uart_tx
  import uart_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0200,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        mem_write_i,
  input  logic [31:0] data_address_i,
  input  logic [31:0] write_data_i,
  output logic        sel_o,
  output logic [31:0] read_data_o,
  output logic        tx_o,
  output logic        busy_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0] offset;
  logic        wr_txdata;
  logic        wr_status;
  logic        wr_baud;

  logic        fifo_pop;
  logic [7:0]  fifo_data;
  logic        fifo_full;
  logic        fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [2:0]  count_sat;

  logic        overflow;
  logic [15:0] div;

  tx_state_t   state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [7:0]  shreg, shreg_n;
  logic [15:0] fdiv, fdiv_n;
  logic        tx, tx_n;

  logic        unused_wdata;
  assign unused_wdata = ^write_data_i[31:16];

  assign offset = data_address_i - BASE_ADDR;
  assign sel_o  = (data_address_i[1:0] == 2'b00) &&
                  (data_address_i >= BASE_ADDR) && (offset < WINDOW_LEN);

  assign wr_txdata = mem_write_i && sel_o && (offset == TXDATA_OFF);
  assign wr_status = mem_write_i && sel_o && (offset == STATUS_OFF);
  assign wr_baud   = mem_write_i && sel_o && (offset == BAUD_OFF);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (wr_txdata),
    .data_i  (write_data_i[7:0]),
    .pop_i   (fifo_pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign count_sat = (32'(fifo_count) > 32'd7) ? 3'd7 : 3'(fifo_count);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overflow <= 1'b0;
      div      <= DEFAULT_DIV;
    end else begin
      if (wr_status) overflow <= 1'b0;
      else if (wr_txdata && fifo_full && !fifo_pop) overflow <= 1'b1;
      if (wr_baud) div <= write_data_i[15:0];
    end
  end

  always_comb begin
    read_data_o = '0;
    if (sel_o) begin
      case (offset)
        STATUS_OFF: begin
          read_data_o[ST_FULL]                = fifo_full;
          read_data_o[ST_EMPTY]               = fifo_empty;
          read_data_o[ST_ACTIVE]              = (state != IDLE);
          read_data_o[ST_OVF]                 = overflow;
          read_data_o[ST_CNT_MSB:ST_CNT_LSB]  = count_sat;
        end
        BAUD_OFF: read_data_o = {16'h0000, div};
        default:  read_data_o = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      fdiv    <= DEFAULT_DIV;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
      fdiv    <= fdiv_n;
      tx      <= tx_n;
    end
  end

  // The divisor is sampled only when a byte is popped, so BAUD writes land on the next frame.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    fdiv_n    = fdiv;
    tx_n      = tx;
    fifo_pop  = 1'b0;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shreg_n  = fifo_data;
          fdiv_n   = eff_div(div);
          cnt_n    = eff_div(div) - 16'd1;
          tx_n     = 1'b0;
          state_n  = START;
        end
      end
      START: begin
        if (cnt == '0) begin
          state_n   = DATA;
          bit_idx_n = '0;
          cnt_n     = fdiv - 16'd1;
          tx_n      = shreg[0];
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      DATA: begin
        if (cnt == '0) begin
          cnt_n = fdiv - 16'd1;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            shreg_n   = {1'b0, shreg[7:1]};
            tx_n      = shreg[1];
          end
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      STOP: begin
        if (cnt == '0) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shreg_n  = fifo_data;
            fdiv_n   = eff_div(div);
            cnt_n    = eff_div(div) - 16'd1;
            tx_n     = 1'b0;
            state_n  = START;
          end else begin
            tx_n    = 1'b1;
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign tx_o   = tx;
  assign busy_o = (state != IDLE) || !fifo_empty;

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the processor's data-store path, downstream of the core's store interface.
- Consumes `mem_write`, `data_address` and `write_data` from the core.
- Stores to its address window are queued in a small FIFO and serialised 8N1, LSB first, on `tx_o`.
- A status word is returned combinationally for loads.

Parameters:
- BASE_ADDR, 32'h0000_0200, word-aligned base of the 3-register window.
- FIFO_DEPTH, 4, TX byte queue entries (power of 2, ≥2).
- DEFAULT_DIV, 16, clock cycles per serial bit after reset.

Ports:
- clk_i  in  1  system clock, rising edge
- rst_ni  in  1  asynchronous, active-low reset
- mem_write_i  in  1  store strobe from core
- data_address_i  in  32  byte address from core
- write_data_i  in  32  store data from core
- sel_o  out  1  address falls on a mapped register (combinational)
- read_data_o  out  32  register read value (combinational), 0 when sel_o=0
- tx_o  out  1  serial line, idle high (registered)
- busy_o  out  1  frame in progress or FIFO non-empty

Behaviour:
- Register map, word offsets from BASE_ADDR:
  - +0 TXDATA: store pushes write_data_i[7:0]; reads return 0.
  - +4 STATUS, read-only except bit 4:
    - bit0 full, bit1 empty, bit2 frame active, bit3 reserved 0.
    - bit4 overflow (sticky); cleared by any store to +4.
    - bits[7:5] FIFO count (saturating at 7); others 0.
  - +8 BAUD: store loads divisor from write_data_i[15:0]; read returns current divisor, zero-extended.
- Stores to other addresses, or to non-word-aligned addresses, are ignored; sel_o=0 for them.
- Reset (async assert, sync release):
  - tx_o=1, busy_o=0, FIFO empty, overflow=0, divisor=DEFAULT_DIV, FSM=IDLE.
  - Assertion mid-frame aborts the frame; tx_o goes high immediately.
- Push:
  - Accepted at the store edge if count<FIFO_DEPTH, or if a pop occurs on the same edge.
  - Otherwise the byte is dropped and overflow is set.
- FSM states IDLE, START, DATA, STOP; tx_o is driven from registered state.
  - IDLE: on an edge where count≠0, pop the head byte, latch it and the current divisor (frame divisor), go to START.
    - A store at edge N into an empty FIFO with FSM idle → pop at edge N+1 → tx_o=0 from N+1.
  - START: tx_o=0 for frame divisor cycles, then DATA.
  - DATA: 8 bits, LSB first, each held for frame divisor cycles; bit index 0..7; after bit 7 go to STOP.
  - STOP: tx_o=1 for frame divisor cycles.
    - If count≠0 at the last STOP cycle, pop and go straight to START (back-to-back frames, no idle gap).
    - Otherwise go to IDLE.
- Frame length is exactly 10×div cycles.
- Divisor values <2 are treated as 2.
- A BAUD write during a frame affects only the next frame.
- Baud counter counts div-1 down to 0, reloading at each bit boundary.
- busy_o = (state≠IDLE) | (count≠0), registered-equivalent timing.

Decomposition:
- Package uart_mmio_pkg holds:
  - offset constants TXDATA_OFF=0, STATUS_OFF=4, BAUD_OFF=8;
  - STATUS bit-index constants;
  - tx_state_t enum {IDLE, START, DATA, STOP}.
- Sub-module sync_fifo (parameterised WIDTH/DEPTH):
  - push/pop/full/empty/count;
  - same async active-low reset;
  - simultaneous push+pop when full is legal.

Test Plan:
- Reset, then one store of 0x55 to 0x200 at edge N, default div=16:
  - tx_o low over cycles N+1..N+16;
  - then 1,0,1,0,1,0,1,0 for 16 cycles each, then high for 16;
  - busy_o falls 160 cycles after N+1.
- Store 0x0003 to 0x208, then 0xA5 to 0x200: each bit lasts 3 cycles, frame = 30 cycles, data pattern 1,0,1,0,0,1,0,1.
- Six back-to-back stores 0x01..0x06 to 0x200 on edges 0..5:
  - 0x01 in flight, 0x02..0x05 queued, 0x06 dropped;
  - load 0x204 returns full=1, overflow=1, count=4;
  - serial output is 0x01..0x05 with no idle gaps;
  - a store to 0x204 clears overflow.
- Store to 0x20C and to 0x201: sel_o=0, FIFO and registers unchanged, read_data_o=0.
- BAUD write of 8 during the first frame of a two-byte burst: the first frame keeps 16 cycles/bit, the second uses 8.
- Assert rst_ni mid-DATA: tx_o=1 in the same cycle without a clock edge; after release, STATUS reads empty=1, BAUD reads 16.
